// File: rtl/reliable_link_pkg.sv
// Shared types and helpers for the stop-and-wait ARQ link.
package reliable_link_pkg;

  localparam int LINK_DATA_W = 8;

  typedef struct packed {
    logic                   seq;
    logic [LINK_DATA_W-1:0] data;
    logic                   par;
  } frame_t;

  typedef struct packed {
    logic valid;
    logic ack_seq;
    logic nak;
  } rsp_t;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, NEXT, DONE} send_state_e;

  // Message word i = 3*i + 1, wrapped to the payload width
  function automatic logic [LINK_DATA_W-1:0] rom_word(input logic [7:0] idx);
    logic [LINK_DATA_W-1:0] i_w;
    i_w = LINK_DATA_W'(idx);
    return i_w * LINK_DATA_W'(3) + LINK_DATA_W'(1);
  endfunction

  // Even parity over seq and data
  function automatic logic frame_par(input logic seq, input logic [LINK_DATA_W-1:0] data);
    return ^{seq, data};
  endfunction

endpackage

// File: rtl/reliable_main_if.sv
// Observation bundle of the link plus the return-path loss test hook.
interface reliable_main_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [7:0]        rx_count;
  logic [15:0]       retx_count;
  logic              done;
  logic              hook_drop_rsp;

  modport master (output rx_data, rx_valid, rx_count, retx_count, done,
                  input  hook_drop_rsp);
  modport slave  (input  rx_data, rx_valid, rx_count, retx_count, done,
                  output hook_drop_rsp);
endinterface

// File: rtl/reliable_main_channel.sv
// Fixed-latency channel pipeline with LFSR-driven corruption and drop.
module link_channel #(
  parameter int W        = 10,
  parameter int LAT      = 2,
  parameter bit ERR_EN   = 1'b0,
  parameter int FLIP_BIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [7:0]     lfsr_q, lfsr_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [W-1:0]   dat_q [LAT];
  logic [W-1:0]   dat_d [LAT];
  logic           ent_valid;
  logic [W-1:0]   ent_data;

  // Advance the LFSR per injected frame and shape the entering frame from its new value
  always_comb begin
    lfsr_d    = lfsr_q;
    ent_valid = in_valid;
    ent_data  = in_data;
    if (in_valid) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (ERR_EN && lfsr_d[2:0] == 3'b000) ent_data[FLIP_BIT] = ~in_data[FLIP_BIT];
      if (ERR_EN && lfsr_d[2:0] == 3'b111) ent_valid = 1'b0;
    end
  end

  // Shift the pipeline by one stage
  always_comb begin
    vld_d    = '0;
    dat_d    = '{default: '0};
    vld_d[0] = ent_valid;
    dat_d[0] = ent_data;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
      vld_q  <= '0;
      dat_q  <= '{default: '0};
    end else begin
      lfsr_q <= lfsr_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/reliable_main.sv
// Stop-and-wait ARQ link top: sender FSM, lossy forward channel, receiver, clean return channel.
module reliable_main
  import reliable_link_pkg::*;
#(
  parameter int DATA_W  = LINK_DATA_W,
  parameter int MSG_LEN = 16,
  parameter int TIMEOUT = 15,
  parameter int CH_LAT  = 2,
  parameter bit ERR_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  reliable_main_if.master  obs
);

  send_state_e state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        seq_q, seq_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] retx_q, retx_d;
  logic        tx_valid_q, tx_valid_d;
  frame_t      tx_frame_q, tx_frame_d;

  logic              exp_seq_q, exp_seq_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_count_q, rx_count_d;

  logic   fwd_valid;
  frame_t fwd_frame;
  rsp_t   rsp_in;
  logic   ret_valid;
  logic [1:0] ret_data;

  // The frame is registered out of SEND, so injection lands one cycle after SEND
  link_channel #(.W($bits(frame_t)), .LAT(CH_LAT), .ERR_EN(ERR_EN), .FLIP_BIT(1)) u_fwd (
    .clk(clk), .rst(rst),
    .in_valid(tx_valid_q), .in_data(tx_frame_q),
    .out_valid(fwd_valid), .out_data(fwd_frame)
  );

  link_channel #(.W(2), .LAT(CH_LAT), .ERR_EN(1'b0), .FLIP_BIT(0)) u_ret (
    .clk(clk), .rst(rst),
    .in_valid(rsp_in.valid & ~obs.hook_drop_rsp), .in_data({rsp_in.ack_seq, rsp_in.nak}),
    .out_valid(ret_valid), .out_data(ret_data)
  );

  // Sender next-state: frame injection, response/timeout handling, message advance
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    timer_d    = timer_q;
    retx_d     = retx_q;
    tx_valid_d = 1'b0;
    tx_frame_d = tx_frame_q;
    unique case (state_q)
      IDLE: state_d = SEND;
      SEND: begin
        tx_valid_d      = 1'b1;
        tx_frame_d.seq  = seq_q;
        tx_frame_d.data = rom_word(idx_q);
        tx_frame_d.par  = frame_par(seq_q, rom_word(idx_q));
        timer_d         = '0;
        state_d         = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 16'd1;
        if (ret_valid) begin
          if (!ret_data[0] && ret_data[1] == seq_q) begin
            state_d = NEXT;
          end else begin
            if (retx_q != '1) retx_d = retx_q + 16'd1;
            state_d = SEND;
          end
        end else if (timer_q == 16'(TIMEOUT)) begin
          if (retx_q != '1) retx_d = retx_q + 16'd1;
          state_d = SEND;
        end
      end
      NEXT: begin
        idx_d   = idx_q + 8'd1;
        seq_d   = ~seq_q;
        state_d = (32'(idx_d) == MSG_LEN) ? DONE : SEND;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Receiver: check parity and sequence, deliver in order, respond the same cycle
  always_comb begin
    exp_seq_d  = exp_seq_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_count_d = rx_count_q;
    rsp_in     = '0;
    if (fwd_valid) begin
      rsp_in.valid   = 1'b1;
      rsp_in.ack_seq = fwd_frame.seq;
      if (frame_par(fwd_frame.seq, fwd_frame.data) != fwd_frame.par) begin
        rsp_in.nak = 1'b1;
      end else if (fwd_frame.seq == exp_seq_q) begin
        rx_data_d  = fwd_frame.data;
        rx_valid_d = 1'b1;
        rx_count_d = rx_count_q + 8'd1;
        exp_seq_d  = ~exp_seq_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= 1'b0;
      timer_q    <= '0;
      retx_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_frame_q <= '0;
      exp_seq_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      timer_q    <= timer_d;
      retx_q     <= retx_d;
      tx_valid_q <= tx_valid_d;
      tx_frame_q <= tx_frame_d;
      exp_seq_q  <= exp_seq_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign obs.rx_data    = rx_data_q;
  assign obs.rx_valid   = rx_valid_q;
  assign obs.rx_count   = rx_count_q;
  assign obs.retx_count = retx_q;
  assign obs.done       = (state_q == DONE);

endmodule

// File: tb/tb_reliable_main.sv
// Bench for reliable_main: event-level ARQ schedule model compared every cycle, plus literal pins.
module tb_reliable_main;

  localparam int L    = 2;
  localparam int TO   = 15;
  localparam int N    = 16;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_c = 1'b1;
  logic rst_f = 1'b1;

  reliable_main_if #(.DATA_W(8)) if_c ();
  reliable_main_if #(.DATA_W(8)) if_f ();

  reliable_main #(.DATA_W(8), .MSG_LEN(N), .TIMEOUT(TO), .CH_LAT(L), .ERR_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst_c), .obs(if_c)
  );
  reliable_main #(.DATA_W(8), .MSG_LEN(N), .TIMEOUT(TO), .CH_LAT(L), .ERR_EN(1'b1)) dut_f (
    .clk(clk), .rst(rst_f), .obs(if_f)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit tracking = 1'b0;
  bit sel_f    = 1'b0;
  int pulses   = 0;

  // Expected per-cycle outputs, indexed by cycles since reset release
  bit         exp_v    [MAXC];
  logic [7:0] exp_d    [MAXC];
  int         exp_cnt  [MAXC];
  int         exp_retx [MAXC];
  bit         exp_done [MAXC];
  bit         m_dlv    [MAXC];
  logic [7:0] m_word   [MAXC];
  bit         m_rtx    [MAXC];
  int hook_cycle = -1;
  int model_end  = 0;
  int model_retx = 0;
  int first_dlv  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Walk the protocol attempt by attempt: each attempt either delivers+ACKs, is NAKed, or times out
  function automatic void build_model(input bit err, input int hook_att);
    int s, idx, att, done_at, cnt, r;
    bit seq, rexp, fdrop, corrupt, rdrop;
    logic [7:0] lf, cur;
    for (int c = 0; c < MAXC; c++) begin m_dlv[c] = 0; m_rtx[c] = 0; m_word[c] = 0; end
    s = 1; idx = 0; att = 0; seq = 0; rexp = 0; lf = 8'hA5; done_at = MAXC;
    hook_cycle = -1; first_dlv = -1;
    while (idx < N && s + TO + 2 < MAXC) begin
      lf      = lfsr_step(lf);
      fdrop   = err && lf[2:0] == 3'd7;
      corrupt = err && lf[2:0] == 3'd0;
      rdrop   = (att == hook_att);
      if (rdrop) hook_cycle = s + 1 + L;
      if (fdrop) begin
        m_rtx[s + TO + 2] = 1; s += TO + 2;
      end else if (corrupt) begin
        if (rdrop) begin m_rtx[s + TO + 2] = 1; s += TO + 2; end
        else begin m_rtx[s + 2 + 2*L] = 1; s += 2 + 2*L; end
      end else begin
        if (seq == rexp) begin
          m_dlv[s + 2 + L]  = 1;
          m_word[s + 2 + L] = 8'((3 * idx + 1) % 256);
          if (first_dlv < 0) first_dlv = s + 2 + L;
          rexp = ~rexp;
        end
        if (rdrop) begin m_rtx[s + TO + 2] = 1; s += TO + 2; end
        else begin
          idx++; seq = ~seq;
          if (idx == N) done_at = s + 3 + 2*L;
          s += 3 + 2*L;
        end
      end
      att++;
    end
    cnt = 0; r = 0; cur = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (m_dlv[c]) begin cnt++; cur = m_word[c]; end
      if (m_rtx[c]) r++;
      exp_v[c] = m_dlv[c]; exp_d[c] = cur; exp_cnt[c] = cnt;
      exp_retx[c] = r; exp_done[c] = (c >= done_at);
    end
    model_end  = done_at;
    model_retx = r;
  endfunction

  // Compare the selected DUT against the model every cycle after release
  always @(negedge clk) begin
    if (tracking && cyc < MAXC) begin
      logic v, dn; logic [7:0] d, cn; logic [15:0] rt;
      v  = sel_f ? if_f.rx_valid   : if_c.rx_valid;
      d  = sel_f ? if_f.rx_data    : if_c.rx_data;
      cn = sel_f ? if_f.rx_count   : if_c.rx_count;
      rt = sel_f ? if_f.retx_count : if_c.retx_count;
      dn = sel_f ? if_f.done       : if_c.done;
      if (v === 1'b1) pulses++;
      check("rx_valid", 32'(v), 32'(exp_v[cyc]));
      check("rx_data", 32'(d), 32'(exp_d[cyc]));
      check("rx_count", 32'(cn), 32'(exp_cnt[cyc]));
      check("retx_count", 32'(rt), 32'(exp_retx[cyc]));
      check("done", 32'(dn), 32'(exp_done[cyc]));
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      if_c.hook_drop_rsp = (cyc == hook_cycle);
    end
  endtask

  task automatic restart(input bit f);
    tracking = 1'b0;
    if (f) rst_f = 1'b1; else rst_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (f) rst_f = 1'b0; else rst_c = 1'b0;
    cyc = 0; sel_f = f; pulses = 0; tracking = 1'b1;
  endtask

  task automatic check_zero(input string tag, input bit f);
    check({tag, "_rx_valid"}, 32'(f ? if_f.rx_valid : if_c.rx_valid), 0);
    check({tag, "_rx_data"}, 32'(f ? if_f.rx_data : if_c.rx_data), 0);
    check({tag, "_rx_count"}, 32'(f ? if_f.rx_count : if_c.rx_count), 0);
    check({tag, "_retx"}, 32'(f ? if_f.retx_count : if_c.retx_count), 0);
    check({tag, "_done"}, 32'(f ? if_f.done : if_c.done), 0);
  endtask

  initial begin
    if_c.hook_drop_rsp = 1'b0;
    if_f.hook_drop_rsp = 1'b0;

    // Reset: outputs all zero while rst is held
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_c", 1'b0);
    check_zero("reset_f", 1'b1);

    // Clean run
    build_model(1'b0, -1);
    check("model_first_delivery_cycle", 32'(first_dlv), 32'd5);
    check("model_clean_retx", 32'(model_retx), 32'd0);
    rst_c = 1'b0; cyc = 0; sel_f = 1'b0; pulses = 0; tracking = 1'b1;
    run(model_end + 10);
    tracking = 1'b0;
    check("clean_rx_count", 32'(if_c.rx_count), 32'd16);
    check("clean_retx", 32'(if_c.retx_count), 32'd0);
    check("clean_done", 32'(if_c.done), 32'd1);
    check("clean_last_word", 32'(if_c.rx_data), 32'd46);
    check("clean_pulses", 32'(pulses), 32'd16);

    // Faulty run: LFSR drops the 7th and 11th injections, each recovered by timeout
    build_model(1'b1, -1);
    check("model_faulty_retx", 32'(model_retx), 32'd2);
    restart(1'b1);
    run(model_end + 10);
    tracking = 1'b0;
    check("faulty_rx_count", 32'(if_f.rx_count), 32'd16);
    check("faulty_retx", 32'(if_f.retx_count), 32'd2);
    check("faulty_done", 32'(if_f.done), 32'd1);
    check("faulty_pulses", 32'(pulses), 32'd16);
    rst_f = 1'b1;

    // Duplicate: first ACK lost on the return path, resend is re-ACKed without delivery
    build_model(1'b0, 0);
    check("model_hook_cycle", 32'(hook_cycle), 32'd4);
    restart(1'b0);
    run(model_end + 10);
    tracking = 1'b0;
    check("dup_rx_count", 32'(if_c.rx_count), 32'd16);
    check("dup_retx", 32'(if_c.retx_count), 32'd1);
    check("dup_pulses", 32'(pulses), 32'd16);
    hook_cycle = -1;
    if_c.hook_drop_rsp = 1'b0;

    // Reset mid-transfer at rx_count == 5, then restart from word 1
    build_model(1'b0, -1);
    restart(1'b0);
    for (int i = 0; i < 200 && if_c.rx_count != 8'd5; i++) run(1);
    check("mid_reached_count5", 32'(if_c.rx_count), 32'd5);
    tracking = 1'b0;
    rst_c = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_reset", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_c = 1'b0; cyc = 0; pulses = 0; tracking = 1'b1;
    run(6);
    check("mid_first_word", 32'(if_c.rx_data), 32'd1);
    run(14);
    tracking = 1'b0;
    check("mid_third_word", 32'(if_c.rx_data), 32'd7);
    check("mid_rx_count", 32'(if_c.rx_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
